// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer: time-multiplexed MAC + sigmoid LUT controller for one fully connected layer
module neuron_layer_sequencer #(
  parameter int N_INPUTS = 49,
  parameter int N_NEURONS = 10,
  parameter int LUT_LATENCY = 2,
  localparam int IW = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1,
  localparam int WW = N_NEURONS * (N_INPUTS + 1) > 1 ? $clog2(N_NEURONS * (N_INPUTS + 1)) : 1,
  localparam int OW = N_NEURONS > 1 ? $clog2(N_NEURONS) : 1,
  localparam int CW = $clog2(LUT_LATENCY + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [IW-1:0]        in_addr,
  input  logic signed [31:0]   in_data,
  output logic [WW-1:0]        w_addr,
  input  logic signed [31:0]   w_data,
  output logic [11:0]          lut_addr,
  input  logic [7:0]           lut_q,
  output logic                 out_we,
  output logic [OW-1:0]        out_addr,
  output logic [7:0]           out_data
);
  typedef enum logic [2:0] {IDLE, MAC, BIAS, SAT, LUT_WAIT, WRITE, DONE} state_t;
  state_t state;
  logic signed [31:0] acc, prod, t;
  logic [CW-1:0] wait_cnt;
  assign prod = in_data * w_data;
  assign t = acc + w_data;
  // the sigmoid ROM answers exactly in the WRITE cycle, so the activation is passed straight through
  assign out_data = out_we ? lut_q : 8'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_we   <= 1'b0;
      out_addr <= '0;
      in_addr  <= '0;
      w_addr   <= '0;
      lut_addr <= '0;
      acc      <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= MAC;
          busy     <= 1'b1;
          in_addr  <= '0;
          w_addr   <= '0;
          out_addr <= '0;
        end
        MAC: begin
          // data arrives one cycle after its address, so the first MAC cycle only clears
          acc    <= in_addr == '0 ? '0 : acc + prod;
          w_addr <= w_addr + WW'(1);
          if (in_addr == IW'(N_INPUTS - 1)) state <= BIAS;
          else in_addr <= in_addr + IW'(1);
        end
        BIAS: begin
          acc   <= acc + prod;
          state <= SAT;
        end
        SAT: begin
          lut_addr <= t > 32767 ? 12'hfff : t < -32768 ? 12'h000 : {~t[15], t[14:4]};
          wait_cnt <= '0;
          state    <= LUT_WAIT;
        end
        LUT_WAIT: if (wait_cnt == CW'(LUT_LATENCY - 1)) begin
          state  <= WRITE;
          out_we <= 1'b1;
        end else wait_cnt <= wait_cnt + CW'(1);
        WRITE: begin
          out_we <= 1'b0;
          if (out_addr == OW'(N_NEURONS - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= MAC;
            out_addr <= out_addr + OW'(1);
            in_addr  <= '0;
            w_addr   <= w_addr + WW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// tb_neuron_layer_sequencer: table-driven and randomized checks of the layer sequencer against a behavioural model
module tb_neuron_layer_sequencer;
  localparam int NI = 4, NN = 2, LL = 2, P = NI + LL + 3, NW = NN * (NI + 1);
  logic clk = 0, rst = 1, start = 0;
  logic busy, done, out_we;
  logic [1:0] in_addr;
  logic [3:0] w_addr;
  logic [0:0] out_addr;
  logic [11:0] lut_addr;
  logic [7:0] lut_q, out_data;
  logic signed [31:0] in_data = 0, w_data = 0;
  logic [7:0] lp [LL];
  int in_mem [NI];
  int w_mem [NW];
  int exp_lut [NN];
  int edges = 0, checks = 0, failures = 0, cur = 0;

  neuron_layer_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN), .LUT_LATENCY(LL)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
    .lut_addr(lut_addr), .lut_q(lut_q), .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // synchronous memories: input buffer, weight ROM and a sigmoid ROM returning addr[11:4]
  always @(posedge clk) begin
    edges <= edges + 1;
    in_data <= in_mem[in_addr];
    w_data <= w_mem[w_addr];
    lp[0] <= lut_addr[11:4];
    for (int i = 1; i < LL; i++) lp[i] <= lp[i-1];
  end
  assign lut_q = lp[LL-1];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cur, act, exp);
    end
  endtask

  function automatic int ref_lut(input int n);
    int t = 0;
    for (int k = 0; k < NI; k++) t += in_mem[k] * w_mem[n*(NI+1)+k];
    t += w_mem[n*(NI+1)+NI];
    return t > 32767 ? 4095 : t < -32768 ? 0 : (t + 32768) / 16;
  endfunction

  // called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after the pass
  task automatic run_pass(input int x0, input int x1, input int rst_at);
    int n, j;
    bit aborted, exp_we;
    start = 1;
    for (int c = 1; c <= NN*P + 2; c++) begin
      @(negedge clk);
      cur = c;
      start = (c == x0 || c == x1);
      rst = (c == rst_at);
      aborted = rst_at > 0 && c > rst_at;
      n = (c - 1) / P;
      j = (c - 1) % P;
      exp_we = !aborted && n < NN && j == P - 1;
      chk("busy", busy, !aborted && c <= NN*P + 1);
      chk("out_we", out_we, exp_we);
      chk("done", done, !aborted && c == NN*P + 1);
      if (!aborted && n < NN && j < NI) begin
        chk("in_addr", in_addr, j);
        chk("w_addr", w_addr, n*(NI+1) + j);
      end
      if (!aborted && n < NN && j == NI) chk("w_addr_bias", w_addr, n*(NI+1) + NI);
      if (exp_we) begin
        chk("out_addr", out_addr, n);
        chk("lut_addr", lut_addr, exp_lut[n]);
        chk("out_data", out_data, exp_lut[n] / 16);
      end
    end
    start = 0;
    rst = 0;
  endtask

  typedef struct {
    int ins [NI];
    int ws [NW];
    int lut [NN];
    int x0, x1, rst_at, gap;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cur);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{ins: '{16, 16, 16, 16}, ws: '{1, 2, 3, 4, 10, 0, 0, 0, 0, 0}, lut: '{2058, 2048}, x0: -1, x1: -1, rst_at: 0, gap: 2};
    tbl[1] = '{ins: '{16, 16, 16, 16}, ws: '{1, 2, 3, 4, 10, 0, 0, 0, 0, 0}, lut: '{2058, 2048}, x0: 3, x1: 12, rst_at: 0, gap: 0};
    tbl[2] = '{ins: '{1000, 1000, 1000, 1000}, ws: '{100, 100, 100, 100, 0, -100, -100, -100, -100, 0}, lut: '{4095, 0}, x0: -1, x1: -1, rst_at: 0, gap: 0};
    tbl[3] = '{ins: '{65536, 65536, 65536, 65536}, ws: '{65536, 65536, 65536, 65536, -5, 65536, 65536, 65536, 65536, -5}, lut: '{2047, 2047}, x0: -1, x1: -1, rst_at: 0, gap: 2};
    tbl[4] = '{ins: '{16, 16, 16, 16}, ws: '{1, 2, 3, 4, 10, 0, 0, 0, 0, 0}, lut: '{2058, 2048}, x0: -1, x1: -1, rst_at: 5, gap: 2};
    tbl[5] = '{ins: '{16, 16, 16, 16}, ws: '{1, 2, 3, 4, 10, 0, 0, 0, 0, 0}, lut: '{2058, 2048}, x0: -1, x1: -1, rst_at: 0, gap: 2};
    for (int k = 0; k < NI; k++) in_mem[k] = 0;
    for (int k = 0; k < NW; k++) w_mem[k] = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_we", out_we, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_addr", in_addr, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_lut_addr", lut_addr, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    for (int v = 0; v < 6; v++) begin
      in_mem = tbl[v].ins;
      w_mem = tbl[v].ws;
      exp_lut = tbl[v].lut;
      run_pass(tbl[v].x0, tbl[v].x1, tbl[v].rst_at);
      repeat (tbl[v].gap) @(negedge clk);
    end
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NI; k++) in_mem[k] = r % 2 ? int'($urandom) : int'($urandom_range(0, 400)) - 200;
      for (int k = 0; k < NW; k++) w_mem[k] = r % 2 ? int'($urandom) : int'($urandom_range(0, 400)) - 200;
      for (int n = 0; n < NN; n++) exp_lut[n] = ref_lut(n);
      run_pass(int'($urandom_range(2, NN*P)), -1, 0);
      repeat (r % 3) @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/neuron_layer_sequencer.md
# neuron_layer_sequencer

Time-multiplexed controller for one fully connected layer. A single shared multiply-accumulate path and a single sigmoid lookup are sequenced over N_NEURONS neurons of N_INPUTS inputs each. The block fetches inputs and weights from synchronous memories, adds the bias, saturates the sum and forms the sigmoid LUT address. It writes each 8-bit activation into the layer output buffer. It sits between the input buffer, weight ROM and sigmoid ROM of a layer and the next layer's input buffer.

## Interface
- N_INPUTS, 49, inputs per neuron.
- N_NEURONS, 10, neurons in the layer.
- LUT_LATENCY, 2, read latency of the sigmoid ROM in cycles (≥1).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a layer pass; sampled only in IDLE.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse at end of pass.
- in_addr  out  clog2(N_INPUTS)  input buffer read address.
- in_data  in  32 signed  input word; valid the cycle after in_addr.
- w_addr  out  clog2(N_NEURONS*(N_INPUTS+1))  weight ROM address.
- w_data  in  32 signed  weight word; valid the cycle after w_addr.
- lut_addr  out  12  sigmoid ROM address (registered).
- lut_q  in  8  sigmoid ROM data; valid LUT_LATENCY cycles after lut_addr.
- out_we  out  1  output buffer write strobe.
- out_addr  out  clog2(N_NEURONS)  output buffer address (neuron index).
- out_data  out  8  activation value.

## Operation
- Weight layout: neuron n, input k is at n*(N_INPUTS+1)+k; the bias of neuron n is at n*(N_INPUTS+1)+N_INPUTS.
- FSM states: IDLE, MAC, BIAS, SAT, LUT_WAIT, WRITE, DONE.
- IDLE, start=1 → MAC with n=0, k=0; start=0 → stay in IDLE.
- MAC (N_INPUTS cycles):
  - Issue in_addr=k and w_addr=base(n)+k, then k++.
  - Accumulator cleared on the first MAC cycle.
  - From the second MAC cycle, acc += in_data*w_data.
  - After k=N_INPUTS-1 → BIAS.
- BIAS (1 cycle): issue w_addr=base(n)+N_INPUTS; accumulate the final product.
- SAT (1 cycle):
  - t = acc + w_data.
  - s = clamp(t, -32768, 32767).
  - lut_addr ← (s+32768)[15:4], so -32768→0 and 32767→4095.
  - → LUT_WAIT.
- LUT_WAIT (LUT_LATENCY cycles), then → WRITE.
- WRITE (1 cycle): out_we=1, out_addr=n, out_data=lut_q.
  - If n<N_NEURONS-1: n++, k=0, → MAC.
  - Else → DONE.
- DONE (1 cycle): done=1, → IDLE.
- Arithmetic:
  - Products are 32-bit signed, truncated.
  - Accumulator and bias add are 32-bit two's complement, wrapping.
  - Saturation is applied only to the final 32-bit sum.
- start while busy is ignored; it is neither queued nor restarting.
- rst (any state, including mid-MAC or WRITE) → IDLE next edge. No further out_we; partial results are discarded.
- Reset values: busy=0, done=0, out_we=0, out_addr=0, out_data=0, in_addr=0, w_addr=0, lut_addr=0; accumulator=0.
- Outside the cycles where they are meaningful, in_addr and w_addr hold their last value.

## Timing
- Cycle 0: start sampled in IDLE. Cycle 1: first MAC address issued; busy rises.
- Per neuron: N_INPUTS + LUT_LATENCY + 3 cycles (P).
- Neuron n write cycle: 1 + n*P + (P-1).
- done pulses at cycle N_NEURONS*P + 1; busy falls the cycle after.
- Exactly N_NEURONS out_we pulses per pass, with out_addr ascending 0..N_NEURONS-1.
- out_we is never high on two consecutive cycles.
- A back-to-back start in the cycle after done (IDLE) is accepted.

## Test plan
Bench parameters: N_INPUTS=4, N_NEURONS=2, LUT_LATENCY=2 (P=9). The sigmoid ROM model returns lut_q=addr[11:4].
- Nominal: inputs all 16; neuron 0 weights 1,2,3,4, bias 10 → t=170, lut_addr=2058, out_data=128 at out_addr 0, cycle 9.
- Second neuron: weights all 0, bias 0 → lut_addr=2048, out_data=128 at out_addr 1, cycle 18; done at cycle 19; busy low at cycle 20.
- Saturation:
  - inputs 1000, weights 100 → t=400000 → lut_addr=4095, out_data=255.
  - weights -100 → lut_addr=0, out_data=0.
- Wrap: inputs 0x10000, weights 0x10000 (each product truncates to 0), bias -5 → t=-5 → lut_addr=2047, out_data=127.
- start pulsed at cycles 3 and 12 while busy → ignored; exactly 2 writes and one done, at cycle 19.
- rst asserted at cycle 5 (mid-MAC) → IDLE at cycle 6, busy=0, no out_we. A fresh start then gives the nominal results with nominal timing.
